// File: rtl/fmc_dvidp_i2c_master.sv
// fmc_dvidp_i2c_master
// Hardware I2C master for single-register transactions on the FMC-DVI/DP bus.
// The requester supplies device/register/data with a REQ pulse; the block runs
// START, address, register, data (or repeated-START and read) and STOP, then
// pulses DONE with NACK status. SCL is driven open-loop (no clock stretching).
// Optional feature macro: I2C_READ_EN adds the register-read path
// (RSTART/DEVR/RDATA states and RD_DAT). Without it every request is a write.
module fmc_dvidp_i2c_master #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       REQ,
   input  logic       REQ_RD,
   input  logic [6:0] DEV_ADR,
   input  logic [7:0] REG_ADR,
   input  logic [7:0] WR_DAT,
   output logic       BUSY,
   output logic       DONE,
   output logic       NACK,
   output logic [7:0] RD_DAT,
   output logic       SCL_OUT,
   output logic       SDA_OUT,
   input  logic       SDA_IN
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_DEVW,
      ST_REG,
      ST_DATA,
`ifdef I2C_READ_EN
      ST_RSTART,
      ST_DEVR,
      ST_RDATA,
`endif
      ST_STOP,
      ST_DONE
   } state_t;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 32'd1);

   // Bus drive for a given slot state/phase/bit; returns {scl, sda}, 1 = released.
   function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] qtr,
                                            input logic [3:0] bit_idx, input logic [7:0] tx);
      logic [1:0] drv;
      logic       scl_hi;
      logic       dat;
      scl_hi = (qtr == 2'd1) || (qtr == 2'd2);
      if (bit_idx == 4'd8) begin
         dat = 1'b1;
      end else begin
         dat = tx[3'd7 - bit_idx[2:0]];
      end
      drv = 2'b11;
      case (st)
         ST_START: begin
            case (qtr)
               2'd0, 2'd1: drv = 2'b11;
               2'd2:       drv = 2'b10;
               default:    drv = 2'b00;
            endcase
         end
         ST_STOP: begin
            case (qtr)
               2'd0:    drv = 2'b00;
               2'd1:    drv = 2'b10;
               default: drv = 2'b11;
            endcase
         end
`ifdef I2C_READ_EN
         ST_RSTART: begin
            case (qtr)
               2'd0:    drv = 2'b01;
               2'd1:    drv = 2'b11;
               2'd2:    drv = 2'b10;
               default: drv = 2'b00;
            endcase
         end
         ST_DEVR:  drv = {scl_hi, dat};
         ST_RDATA: drv = {scl_hi, 1'b1};
`endif
         ST_DEVW, ST_REG, ST_DATA: drv = {scl_hi, dat};
         default: drv = 2'b11;
      endcase
      return drv;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [1:0]  qtr_q, qtr_d;
   logic [3:0]  bit_q, bit_d;
   logic        err_q, err_d;
   logic [6:0]  dev_q;
   logic [7:0]  reg_q;
   logic [7:0]  wdat_q;
   logic        ack_q;
   logic        busy_q, done_q, nack_q, scl_q, sda_q;
   logic [7:0]  rdat_q;

   logic        accept_s;
   logic        tick_s;
   logic        slot_end_s;
   logic        last_bit_s;
   logic        byte_st_s;
   logic        sample_s;
   logic        rd_req_s;
   logic [7:0]  tx_s;
   logic [1:0]  drv_s;

`ifdef I2C_READ_EN
   logic        rd_q;
   logic [7:0]  shd_q;
   assign rd_req_s = rd_q;
`else
   logic        unused_req_rd_s;
   assign unused_req_rd_s = REQ_RD;
   assign rd_req_s        = 1'b0;
`endif

   assign accept_s   = REQ && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign tick_s     = (div_q == DIV_LAST);
   assign slot_end_s = tick_s && (qtr_q == 2'd3);
   assign last_bit_s = (bit_q == 4'd8);
`ifdef I2C_READ_EN
   assign byte_st_s  = (state_q == ST_DEVW) || (state_q == ST_REG) || (state_q == ST_DATA) ||
                       (state_q == ST_DEVR) || (state_q == ST_RDATA);
`else
   assign byte_st_s  = (state_q == ST_DEVW) || (state_q == ST_REG) || (state_q == ST_DATA);
`endif
   assign sample_s   = byte_st_s && (qtr_q == 2'd1) && tick_s;

   // Next-state: slot sequencing, phase/bit counters and ACK-miss tracking
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            div_d = 16'd0;
            qtr_d = 2'd0;
            bit_d = 4'd0;
            if (accept_s) begin
               state_d = ST_START;
               err_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            if (tick_s) begin
               div_d = 16'd0;
               qtr_d = qtr_q + 2'd1;
            end else begin
               div_d = div_q + 16'd1;
            end
            if (slot_end_s) begin
               bit_d = 4'd0;
               case (state_q)
                  ST_START: state_d = ST_DEVW;
                  ST_DEVW: begin
                     if (!last_bit_s) begin
                        bit_d = bit_q + 4'd1;
                     end else if (ack_q) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                     end else begin
                        state_d = ST_REG;
                     end
                  end
                  ST_REG: begin
                     if (!last_bit_s) begin
                        bit_d = bit_q + 4'd1;
                     end else if (ack_q) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                     end else begin
`ifdef I2C_READ_EN
                        state_d = rd_req_s ? ST_RSTART : ST_DATA;
`else
                        state_d = ST_DATA;
`endif
                     end
                  end
                  ST_DATA: begin
                     if (!last_bit_s) begin
                        bit_d = bit_q + 4'd1;
                     end else begin
                        err_d   = err_q | ack_q;
                        state_d = ST_STOP;
                     end
                  end
`ifdef I2C_READ_EN
                  ST_RSTART: state_d = ST_DEVR;
                  ST_DEVR: begin
                     if (!last_bit_s) begin
                        bit_d = bit_q + 4'd1;
                     end else if (ack_q) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                     end else begin
                        state_d = ST_RDATA;
                     end
                  end
                  ST_RDATA: begin
                     if (!last_bit_s) begin
                        bit_d = bit_q + 4'd1;
                     end else begin
                        state_d = ST_STOP;
                     end
                  end
`endif
                  ST_STOP: state_d = ST_DONE;
                  default: state_d = ST_IDLE;
               endcase
            end else begin
               state_d = state_q;
            end
         end
      endcase
   end

   // Byte presented on the bus in the upcoming slot, then pin drive for that slot
   always_comb begin
      tx_s = 8'hFF;
      case (state_d)
         ST_DEVW: tx_s = {dev_q, 1'b0};
         ST_REG:  tx_s = reg_q;
         ST_DATA: tx_s = wdat_q;
`ifdef I2C_READ_EN
         ST_DEVR: tx_s = {dev_q, 1'b1};
`endif
         default: tx_s = 8'hFF;
      endcase
      drv_s = bus_drive(state_d, qtr_d, bit_d, tx_s);
   end

   // State and bit-timing counters
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         div_q   <= 16'd0;
         qtr_q   <= 2'd0;
         bit_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         err_q   <= err_d;
      end
   end

   // Request capture and SDA sampling at the end of P1
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         dev_q  <= 7'd0;
         reg_q  <= 8'd0;
         wdat_q <= 8'd0;
         ack_q  <= 1'b0;
`ifdef I2C_READ_EN
         rd_q   <= 1'b0;
         shd_q  <= 8'd0;
`endif
      end else begin
         if (accept_s) begin
            dev_q  <= DEV_ADR;
            reg_q  <= REG_ADR;
            wdat_q <= WR_DAT;
`ifdef I2C_READ_EN
            rd_q   <= REQ_RD;
`endif
         end
         if (sample_s) begin
            ack_q <= SDA_IN;
         end
`ifdef I2C_READ_EN
         if (sample_s && (state_q == ST_RDATA) && !last_bit_s) begin
            shd_q <= {shd_q[6:0], SDA_IN};
         end
`endif
      end
   end

   // Registered handshake, status and pin outputs
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         nack_q <= 1'b0;
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
         rdat_q <= 8'h00;
      end else begin
         busy_q <= (state_d != ST_IDLE) && (state_d != ST_DONE);
         done_q <= (state_d == ST_DONE);
         scl_q  <= drv_s[1];
         sda_q  <= drv_s[0];
         if (accept_s) begin
            nack_q <= 1'b0;
         end else if (state_d == ST_DONE) begin
            nack_q <= err_q;
         end
`ifdef I2C_READ_EN
         if ((state_q == ST_STOP) && (state_d == ST_DONE) && rd_req_s && !err_q) begin
            rdat_q <= shd_q;
         end
`endif
      end
   end

   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign NACK    = nack_q;
   assign RD_DAT  = rdat_q;
   assign SCL_OUT = scl_q;
   assign SDA_OUT = sda_q;

endmodule
